pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  IF stage and IF/ID pipeline register of the 5-stage MIPS core. Holds the PC and fetches from the
//  combinational instruction memory. Applies redirects from the ID-stage branch resolution logic
//  (branch_taken/branch_target) and from jump decode. Feeds the IF/ID register consumed by decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//  NOP_INSTR 32'h0000_0000  instruction injected into IF/ID on flush/bubble (sll $0,$0,0)
// PORTS
//  clk            in   1   single core clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hazard unit: hold PC and IF/ID this cycle
//  halt_req       in   1   ID decoded halt/break; stop fetching
//  branch_taken   in   1   ID branch resolution: redirect to branch_target
//  branch_target  in   32  PC+4 + (sext(imm)<<2), computed in ID
//  jump           in   1   ID decoded J/JAL/JR: redirect to jump_target
//  jump_target    in   32  jump destination
//  instr_addr     out  32  = pc_q; instruction memory address
//  instr_rdata    in   32  combinational instruction memory read data
//  if_id_instr    out  32  registered instruction to ID
//  if_id_pc4      out  32  registered PC+4 of that instruction
//  if_id_valid    out  1   IF/ID holds a real instruction
//  halted         out  1   fetch FSM is in HALT
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high (clk, rst).
//  Reset: pc_q=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, halted=0, FSM=BOOT.
//  FSM fetch_state_t {BOOT, RUN, HALT}:
//   BOOT: lasts 1 cycle after rst deasserts; pc_q held, IF/ID stays bubble; -> RUN.
//   RUN: normal fetch. halt_req=1 & stall=0 -> HALT.
//   HALT: pc_q frozen; IF/ID loads bubble each cycle; halted=1. Exits only via rst.
//  Next-PC in RUN with stall=0, priority order:
//   branch_taken -> branch_target; else jump -> jump_target; else pc_q+4.
//   Targets are forced to {tgt[31:2],2'b00}. Increment wraps mod 2^32 (32'hFFFF_FFFC -> 0).
//  IF/ID load in RUN with stall=0: instr=instr_rdata, pc4=pc_q+4, valid=1, unless flushed.
//  Flush: (branch_taken|jump) & stall=0 loads bubble (NOP_INSTR, valid=0, pc4 unchanged).
//  Flush behaviour is replaced by the delay-slot rule under BRANCH_DELAY_SLOT_EN.
//  stall=1: pc_q and IF/ID hold. branch_taken, jump and halt_req are ignored.
//   Decode must re-present them once stall drops.
//  Simultaneous halt_req and redirect (stall=0): the redirect updates pc_q, then FSM -> HALT.
//  Latency: redirect asserted in cycle N -> instr_addr=target in N+1; target instr valid in IF/ID in N+2.
//  rst mid-operation overrides everything and returns to BOOT, discarding pending redirects.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined: MIPS architectural delay slot.
//   A redirect does NOT flush IF/ID; the instruction fetched in the redirect cycle loads with valid=1.
//  BRANCH_DELAY_SLOT_EN undefined: redirect flushes IF/ID to a bubble (one-cycle penalty).
// STRUCTURE
//  mips_pkg: fetch_state_t enum, PC_STEP=32'd4, NOP_INSTR default constant, word-align helper fn.
//  Sub-module if_id_reg: instr/pc4/valid register with load, flush and hold inputs.
//  pc_fetch_unit owns pc_q, next-PC mux and the FSM.
// TESTING
//  1 rst 2 cycles, RESET_PC=0x0 -> cycle 1 bubble (BOOT); then if_id_pc4 = 4, 8, 12 with valid=1.
//  2 branch_taken=1, target=0x0000_0040 at pc_q=0x10 -> next instr_addr=0x40.
//    IF/ID: bubble (no macro) / instr@0x10 valid (macro).
//  3 stall=1 for 3 cycles with branch_taken=1 -> pc_q and IF/ID unchanged; no redirect taken.
//  4 branch_taken & jump same cycle, targets 0x80/0x100 -> pc_q=0x80. jump_target=0x103 -> pc_q=0x100.
//  5 pc_q=0xFFFF_FFFC, no redirect -> pc_q=0x0, if_id_pc4=0x0.
//  6 halt_req=1 in RUN -> halted=1 next cycle, pc_q frozen, valid=0 until rst; rst -> BOOT.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch FSM states, PC step, default bubble instruction and a word-align helper
package mips_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID register (clk, rst, load, flush, instr, pc4 -> if_id_instr, if_id_pc4, if_id_valid); flush beats load, neither holds
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_instr <= instr;
      if_id_pc4   <= pc4;
      if_id_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF stage with PC, next-PC mux, BOOT/RUN/HALT FSM and IF/ID register (ports: clk, rst, stall, halt_req, branch_taken/target, jump/target, instr_addr, instr_rdata, if_id_*, halted); BRANCH_DELAY_SLOT_EN keeps the redirect-cycle instruction instead of flushing it
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);
  fetch_state_t state;
  logic [31:0] pc_q, pc_inc, pc_next;
  logic run_go, redirect, flush;
  assign instr_addr = pc_q;
  assign pc_inc     = pc_q + PC_STEP;
  assign run_go     = state == RUN && !stall;
  assign redirect   = branch_taken || jump;
  always_comb pc_next = branch_taken ? word_align(branch_target) : jump ? word_align(jump_target) : pc_inc;
`ifdef BRANCH_DELAY_SLOT_EN
  assign flush = state != RUN;
`else
  assign flush = state != RUN || (run_go && redirect);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BOOT;
      pc_q   <= RESET_PC;
      halted <= 1'b0;
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (run_go) begin
      pc_q <= pc_next;
      if (halt_req) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk), .rst(rst), .load(run_go), .flush(flush),
    .instr(instr_rdata), .pc4(pc_inc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: random + directed stimulus, reference model feeds a scoreboard queue checked by a monitor
module tb_pc_fetch_unit;
  logic clk = 0, rst = 1, stall = 0, halt_req = 0, branch_taken = 0, jump = 0;
  logic [31:0] branch_target = 0, jump_target = 0, instr_addr, instr_rdata;
  logic [31:0] if_id_instr, if_id_pc4;
  logic if_id_valid, halted;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [31:0] addr, instr, pc4;
    logic valid, halted;
  } exp_t;
  exp_t q[$];
  int m_state;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic m_valid, m_halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction
  assign instr_rdata = mem(instr_addr);

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_addr(instr_addr),
    .instr_rdata(instr_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  task automatic step(input logic r, input logic s, input logic h, input logic bt,
                      input logic [31:0] btg, input logic j, input logic [31:0] jtg);
    bit ds;
    @(negedge clk);
    rst = r; stall = s; halt_req = h; branch_taken = bt; branch_target = btg; jump = j; jump_target = jtg;
`ifdef BRANCH_DELAY_SLOT_EN
    ds = 1;
`else
    ds = 0;
`endif
    if (r) begin
      m_state = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_instr = 0; m_valid = 0;
    end else if (m_state == 2) begin
      m_instr = 0; m_valid = 0;
    end else if (!s) begin
      if ((bt || j) && !ds) begin
        m_instr = 0; m_valid = 0;
      end else begin
        m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
      end
      m_pc = bt ? {btg[31:2], 2'b00} : j ? {jtg[31:2], 2'b00} : m_pc + 4;
      if (h) begin
        m_state = 2; m_halted = 1;
      end
    end
    q.push_back('{m_pc, m_instr, m_pc4, m_valid, m_halted});
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr_addr", instr_addr, e.addr);
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        chk("halted", 32'(halted), 32'(e.halted));
      end
    end
  end

  initial begin
    int guard;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 1, 32'h200, 0, 0);
    step(0, 0, 0, 1, 32'h80, 1, 32'h100);
    step(0, 0, 0, 0, 0, 1, 32'h103);
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h60, 0, 0);
    repeat (3) step(0, 0, 0, 1, 32'h20, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom % 40 == 0, $urandom % 5 == 0, $urandom % 50 == 0,
           $urandom % 6 == 0, $urandom & 32'h3FF, $urandom % 7 == 0,
           ($urandom % 10 == 0) ? $urandom : ($urandom & 32'hFFF));
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
